// File: rtl/render_object_list.sv
// render_object_list: double-buffered per-frame object list.
// The host fills the write bank and commits it. The frame controller then swaps it into
// the read bank and pops objects one per handshake.
// Optional feature macro: OBJECT_LIST_REPLAY_EN. When it is defined, a frame start with no
// committed bank replays the previous list. When it is not defined, that frame is empty.
module render_object_list #(
    parameter int MAX_OBJECTS       = 1024,
    parameter int MODEL_INDEX_WIDTH = 4,
    parameter int ANGLE_WIDTH       = 12,
    parameter int POS_WIDTH         = 24,
    parameter int CNT_WIDTH         = $clog2(MAX_OBJECTS + 1)
) (
    input  logic                         clk_100m,
    input  logic                         rstn,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [MODEL_INDEX_WIDTH-1:0] i_wr_model_id,
    input  logic [ANGLE_WIDTH-1:0]       i_wr_angle,
    input  logic signed [POS_WIDTH-1:0]  i_wr_pos [3],
    input  logic                         i_commit,
    output logic [CNT_WIDTH-1:0]         o_wr_count,
    output logic                         o_overflow,
    input  logic                         i_frame_start,
    output logic                         o_obj_valid,
    input  logic                         i_obj_read_en,
    output logic [MODEL_INDEX_WIDTH-1:0] o_model_id,
    output logic [ANGLE_WIDTH-1:0]       o_angle,
    output logic signed [POS_WIDTH-1:0]  o_pos [3],
    output logic                         o_obj_last,
    output logic                         o_frame_done
);

    localparam int IDX_W  = (MAX_OBJECTS > 1) ? $clog2(MAX_OBJECTS) : 1;
    localparam int DEPTH  = 2 ** (IDX_W + 1);
    localparam int WORD_W = MODEL_INDEX_WIDTH + ANGLE_WIDTH + 3 * POS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OBJECTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_ready_q, wr_ready_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0] committed_count_q, committed_count_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_WIDTH-1:0] wr_count_inc;
    logic                 wr_fire, commit_acc, start_acc, at_last;
    logic [IDX_W:0]       wr_addr, rd_addr;
    logic [WORD_W-1:0]    mem [DEPTH];
    logic [WORD_W-1:0]    rd_word_q;

    assign wr_fire    = i_wr_valid && wr_ready_q;
    assign commit_acc = i_commit && !pending_q;
    assign start_acc  = i_frame_start && (state_q == S_IDLE);
    assign wr_addr    = {wr_bank_q, wr_count_q[IDX_W-1:0]};
    assign rd_addr    = {rd_bank_q, rd_idx_q[IDX_W-1:0]};
    assign at_last    = (rd_idx_q == rd_count_q - CNT_WIDTH'(1));

    // Bank bookkeeping: write count, commit/pending, overflow flag and bank swap on frame start
    always_comb begin
        wr_bank_d         = wr_bank_q;
        rd_bank_d         = rd_bank_q;
        pending_d         = pending_q;
        overflow_d        = overflow_q;
        committed_count_d = committed_count_q;
        rd_count_d        = rd_count_q;
        wr_count_inc      = wr_count_q + CNT_WIDTH'(wr_fire);
        wr_count_d        = wr_count_inc;
        if (i_wr_valid && !wr_ready_q && (wr_count_q == MAX_CNT)) begin
            overflow_d = 1'b1;
        end
        if (commit_acc) begin
            pending_d         = 1'b1;
            committed_count_d = wr_count_inc;
            overflow_d        = 1'b0;
        end
        if (start_acc) begin
            if (pending_q || commit_acc) begin
                // A same-cycle commit is swapped straight in, including a write accepted this cycle
                rd_bank_d  = wr_bank_q;
                rd_count_d = pending_q ? committed_count_q : wr_count_inc;
                wr_bank_d  = !wr_bank_q;
                wr_count_d = '0;
                pending_d  = 1'b0;
            end else begin
`ifdef OBJECT_LIST_REPLAY_EN
                rd_count_d = rd_count_q;
`else
                rd_count_d = '0;
`endif
            end
        end
        wr_ready_d = !pending_d && (wr_count_d < MAX_CNT);
    end

    // Read FSM next-state and object index
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    rd_idx_d = '0;
                    state_d  = (rd_count_d == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_d = S_PRESENT;
            S_PRESENT: begin
                if (i_obj_read_en) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + CNT_WIDTH'(1);
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            state_q           <= S_IDLE;
            wr_bank_q         <= 1'b0;
            rd_bank_q         <= 1'b0;
            pending_q         <= 1'b0;
            overflow_q        <= 1'b0;
            wr_ready_q        <= 1'b0;
            wr_count_q        <= '0;
            committed_count_q <= '0;
            rd_count_q        <= '0;
            rd_idx_q          <= '0;
        end else begin
            state_q           <= state_d;
            wr_bank_q         <= wr_bank_d;
            rd_bank_q         <= rd_bank_d;
            pending_q         <= pending_d;
            overflow_q        <= overflow_d;
            wr_ready_q        <= wr_ready_d;
            wr_count_q        <= wr_count_d;
            committed_count_q <= committed_count_d;
            rd_count_q        <= rd_count_d;
            rd_idx_q          <= rd_idx_d;
        end
    end

    // Object storage write port (both banks, bank bit is the address MSB)
    always_ff @(posedge clk_100m) begin
        if (wr_fire) begin
            mem[wr_addr] <= {i_wr_model_id, i_wr_angle, i_wr_pos[0], i_wr_pos[1], i_wr_pos[2]};
        end
    end

    // Object storage read port, loaded only in FETCH so outputs hold through PRESENT
    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            rd_word_q <= '0;
        end else if (state_q == S_FETCH) begin
            rd_word_q <= mem[rd_addr];
        end
    end

    assign {o_model_id, o_angle, o_pos[0], o_pos[1], o_pos[2]} = rd_word_q;
    assign o_obj_valid  = (state_q == S_PRESENT);
    assign o_obj_last   = o_obj_valid && at_last;
    assign o_frame_done = (state_q == S_DONE);
    assign o_wr_ready   = wr_ready_q;
    assign o_wr_count   = wr_count_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_render_object_list.sv
// Directed bench for render_object_list (MAX_OBJECTS=4 build).
// Expectations for an un-committed frame start follow OBJECT_LIST_REPLAY_EN.
module tb_render_object_list;

    localparam int MAXO = 4;
    localparam int MW   = 4;
    localparam int AW   = 12;
    localparam int PW   = 24;
    localparam int CW   = $clog2(MAXO + 1);

    logic                 clk_100m = 1'b0;
    logic                 rstn;
    logic                 i_wr_valid;
    logic                 o_wr_ready;
    logic [MW-1:0]        i_wr_model_id;
    logic [AW-1:0]        i_wr_angle;
    logic signed [PW-1:0] i_wr_pos [3];
    logic                 i_commit;
    logic [CW-1:0]        o_wr_count;
    logic                 o_overflow;
    logic                 i_frame_start;
    logic                 o_obj_valid;
    logic                 i_obj_read_en;
    logic [MW-1:0]        o_model_id;
    logic [AW-1:0]        o_angle;
    logic signed [PW-1:0] o_pos [3];
    logic                 o_obj_last;
    logic                 o_frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_100m = ~clk_100m;

    render_object_list #(
        .MAX_OBJECTS      (MAXO),
        .MODEL_INDEX_WIDTH(MW),
        .ANGLE_WIDTH      (AW),
        .POS_WIDTH        (PW)
    ) dut (
        .clk_100m     (clk_100m),
        .rstn         (rstn),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_model_id(i_wr_model_id),
        .i_wr_angle   (i_wr_angle),
        .i_wr_pos     (i_wr_pos),
        .i_commit     (i_commit),
        .o_wr_count   (o_wr_count),
        .o_overflow   (o_overflow),
        .i_frame_start(i_frame_start),
        .o_obj_valid  (o_obj_valid),
        .i_obj_read_en(i_obj_read_en),
        .o_model_id   (o_model_id),
        .o_angle      (o_angle),
        .o_pos        (o_pos),
        .o_obj_last   (o_obj_last),
        .o_frame_done (o_frame_done)
    );

    task automatic check(input string tag, input integer got, input integer exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_100m);
        #1;
    endtask

    // Object fields are derived from the id: angle=(id-1)*16, pos=(id*256, -3*id, 5000-id)
    task automatic write_obj(input int id);
        i_wr_valid    = 1'b1;
        i_wr_model_id = MW'(id);
        i_wr_angle    = AW'((id - 1) * 16);
        i_wr_pos[0]   = PW'(id * 256);
        i_wr_pos[1]   = PW'(-3 * id);
        i_wr_pos[2]   = PW'(5000 - id);
        tick;
        i_wr_valid = 1'b0;
    endtask

    task automatic expect_obj(input string tag, input int id, input int last);
        check({tag, ".valid"}, 32'(o_obj_valid), 1);
        check({tag, ".model"}, 32'(o_model_id), id);
        check({tag, ".angle"}, 32'(o_angle), (id - 1) * 16);
        check({tag, ".pos_x"}, 32'(o_pos[0]), id * 256);
        check({tag, ".pos_y"}, 32'(o_pos[1]), -3 * id);
        check({tag, ".pos_z"}, 32'(o_pos[2]), 5000 - id);
        check({tag, ".last"},  32'(o_obj_last), last);
    endtask

    task automatic pop;
        i_obj_read_en = 1'b1;
        tick;
        i_obj_read_en = 1'b0;
    endtask

    task automatic start_frame;
        i_frame_start = 1'b1;
        tick;
        i_frame_start = 1'b0;
    endtask

    // Called right after the frame-start edge; expects ids first..first+n-1 then one done pulse
    task automatic read_frame(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, ".fetch_gap"}, 32'(o_obj_valid), 0);
            tick;
            expect_obj(tag, first + i, (i == n - 1) ? 1 : 0);
            if (i == 0) begin
                tick;
                expect_obj({tag, ".hold"}, first, (n == 1) ? 1 : 0);
            end
            pop;
        end
        check({tag, ".done"}, 32'(o_frame_done), 1);
        check({tag, ".done_valid"}, 32'(o_obj_valid), 0);
        tick;
        check({tag, ".done_gone"}, 32'(o_frame_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn          = 1'b0;
        i_wr_valid    = 1'b0;
        i_wr_model_id = '0;
        i_wr_angle    = '0;
        i_wr_pos[0]   = '0;
        i_wr_pos[1]   = '0;
        i_wr_pos[2]   = '0;
        i_commit      = 1'b0;
        i_frame_start = 1'b0;
        i_obj_read_en = 1'b0;

        // Reset state
        tick;
        tick;
        check("rst.valid",    32'(o_obj_valid), 0);
        check("rst.done",     32'(o_frame_done), 0);
        check("rst.overflow", 32'(o_overflow), 0);
        check("rst.wr_count", 32'(o_wr_count), 0);
        check("rst.wr_ready", 32'(o_wr_ready), 0);
        check("rst.model",    32'(o_model_id), 0);
        check("rst.last",     32'(o_obj_last), 0);
        rstn = 1'b1;
        tick;
        check("rel.wr_ready", 32'(o_wr_ready), 1);

        // Three objects, commit, one frame
        write_obj(1);
        write_obj(2);
        write_obj(3);
        check("f1.wr_count", 32'(o_wr_count), 3);
        i_commit = 1'b1;
        tick;
        i_commit = 1'b0;
        check("f1.pend_ready", 32'(o_wr_ready), 0);
        check("f1.pend_count", 32'(o_wr_count), 3);
        start_frame;
        check("f1.swap_count", 32'(o_wr_count), 0);
        check("f1.swap_ready", 32'(o_wr_ready), 1);
        read_frame("f1", 1, 3);

        // Frame start without a commit
        start_frame;
`ifdef OBJECT_LIST_REPLAY_EN
        read_frame("replay", 1, 3);
`else
        check("noreplay.done",  32'(o_frame_done), 1);
        check("noreplay.valid", 32'(o_obj_valid), 0);
        tick;
        check("noreplay.done_gone", 32'(o_frame_done), 0);
        check("noreplay.valid2",    32'(o_obj_valid), 0);
`endif

        // Empty committed list
        i_commit = 1'b1;
        tick;
        i_commit = 1'b0;
        start_frame;
        check("empty.done",  32'(o_frame_done), 1);
        check("empty.valid", 32'(o_obj_valid), 0);
        tick;
        check("empty.done_gone", 32'(o_frame_done), 0);
        check("empty.valid2",    32'(o_obj_valid), 0);

        // Fill to MAX_OBJECTS, overflow, commit clears it
        write_obj(4);
        write_obj(5);
        write_obj(6);
        write_obj(7);
        check("full.count",    32'(o_wr_count), 4);
        check("full.ready",    32'(o_wr_ready), 0);
        check("full.overflow", 32'(o_overflow), 0);
        write_obj(15);
        check("ovf.flag",  32'(o_overflow), 1);
        check("ovf.count", 32'(o_wr_count), 4);
        i_commit = 1'b1;
        tick;
        i_commit = 1'b0;
        check("ovf.cleared", 32'(o_overflow), 0);
        start_frame;
        read_frame("full", 4, 4);

        // Commit and frame start in the same cycle; writes during the frame hit the other bank
        write_obj(8);
        write_obj(9);
        i_commit      = 1'b1;
        i_frame_start = 1'b1;
        tick;
        i_commit      = 1'b0;
        i_frame_start = 1'b0;
        check("swap.fetch",    32'(o_obj_valid), 0);
        check("swap.wr_count", 32'(o_wr_count), 0);
        check("swap.wr_ready", 32'(o_wr_ready), 1);
        write_obj(12);
        check("swap.wr_count1", 32'(o_wr_count), 1);
        expect_obj("swap.o8a", 8, 0);
        write_obj(13);
        check("swap.wr_count2", 32'(o_wr_count), 2);
        expect_obj("swap.o8b", 8, 0);
        pop;
        check("swap.gap", 32'(o_obj_valid), 0);
        tick;
        expect_obj("swap.o9", 9, 1);
        pop;
        check("swap.done", 32'(o_frame_done), 1);
        tick;
        check("swap.done_gone", 32'(o_frame_done), 0);

        // Reset while an object is presented
        i_commit = 1'b1;
        tick;
        i_commit = 1'b0;
        start_frame;
        tick;
        expect_obj("midrst.o12", 12, 0);
        rstn = 1'b0;
        tick;
        check("midrst.valid",    32'(o_obj_valid), 0);
        check("midrst.done",     32'(o_frame_done), 0);
        check("midrst.wr_count", 32'(o_wr_count), 0);
        check("midrst.wr_ready", 32'(o_wr_ready), 0);
        rstn = 1'b1;
        tick;
        check("midrst.rel_ready", 32'(o_wr_ready), 1);
        check("midrst.rel_valid", 32'(o_obj_valid), 0);
        check("midrst.rel_done",  32'(o_frame_done), 0);
        tick;
        check("midrst.rel_done2", 32'(o_frame_done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
